genius_control: RTL

//  Control FSM for the Genius memory game; sits directly upstream of datapath.

---
 rtl/genius_control.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/genius_control.sv
// Genius memory game round sequencer driving the datapath resets/enables.
// Optional GENIUS_ENTER_SYNC_EN: 2-flop synchronizer on ENTER before edge detect.
module genius_control #(
  parameter int p_hold   = 100_000_000,
  parameter int p_hold_w = 27
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       ENTER,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  localparam logic [p_hold_w-1:0] hold_last = p_hold_w'(p_hold - 1);

  state_t              state;
  state_t              state_nx;
  logic [p_hold_w-1:0] hold;
  logic                enter_s;
  logic                enter_q;
  logic                enter_rise;

`ifdef GENIUS_ENTER_SYNC_EN
  logic [1:0] sync;

  // two-flop synchronizer for the asynchronous key level
  always_ff @(posedge CLOCK_50) begin
    if (RESET) sync <= 2'b00;
    else       sync <= {sync[0], ENTER};
  end

  assign enter_s = sync[1];
`else
  assign enter_s = ENTER;
`endif

  // previous key level; held key must not re-trigger across reset
  always_ff @(posedge CLOCK_50) begin
    enter_q <= enter_s;
  end

  assign enter_rise = enter_s & ~enter_q;

  // state register and RESULT hold timer
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= INIT;
      hold  <= '0;
    end else begin
      state <= state_nx;
      if (state == RESULT && state_nx == RESULT)
        hold <= hold + 1'b1;
      else
        hold <= '0;
    end
  end

  // next-state selection from current state and datapath flags
  always_comb begin
    state_nx = INIT;
    case (state)
      INIT:       state_nx = SETUP;
      SETUP:      state_nx = enter_rise ? PLAY_FPGA : SETUP;
      PLAY_FPGA:  state_nx = end_FPGA ? PLAY_USER : PLAY_FPGA;
      PLAY_USER: begin
        if (end_time)        state_nx = RESULT;
        else if (enter_rise) state_nx = CHECK;
        else                 state_nx = PLAY_USER;
      end
      CHECK: begin
        if (!match)        state_nx = RESULT;
        else if (!end_User) state_nx = PLAY_USER;
        else if (win)      state_nx = RESULT;
        else               state_nx = NEXT_ROUND;
      end
      NEXT_ROUND: state_nx = PLAY_FPGA;
      RESULT: begin
        if (enter_rise || hold == hold_last) state_nx = INIT;
        else                                 state_nx = RESULT;
      end
      default:    state_nx = INIT;
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b0;
    case (state)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      SETUP:      E1 = 1'b1;
      PLAY_FPGA: begin
        E2  = 1'b1;
        SEL = 1'b1;
      end
      PLAY_USER: begin
        E3  = 1'b1;
        SEL = 1'b1;
      end
      CHECK:      SEL = 1'b1;
      NEXT_ROUND: begin
        E4  = 1'b1;
        R1  = 1'b1;
        SEL = 1'b1;
      end
      RESULT:     SEL = 1'b1;
      default:    SEL = 1'b0;
    endcase
  end

  assign state_o = state;

endmodule
